// File: rtl/manta_pkg.sv
// Shared definitions for the manta_style pipeline: width helpers, stall reason codes
// and the opcode constants the top level decodes into operand enables and latencies.
package manta_pkg;

  typedef enum logic [1:0] {
    SB_NONE = 2'd0,
    SB_RAW  = 2'd1,
    SB_WAW  = 2'd2,
    SB_WBP  = 2'd3
  } sb_why_e;

  function automatic int sb_reg_w(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  function automatic int sb_cnt_w(input int max_lat);
    return $clog2(max_lat + 2);
  endfunction

  // Major opcode classes seen by ID
  localparam logic [3:0] OP_ALU   = 4'h0;
  localparam logic [3:0] OP_ALUI  = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_MUL   = 4'h4;
  localparam logic [3:0] OP_DIV   = 4'h5;
  localparam logic [3:0] OP_BR    = 4'h6;
  localparam logic [3:0] OP_JAL   = 4'h7;

  typedef struct packed {
    logic       rs1_en;
    logic       rs2_en;
    logic       rd_en;
    logic [2:0] lat;
  } op_info_t;

  // Issue-to-writeback latency and operand usage per opcode class
  function automatic op_info_t op_decode(input logic [3:0] op);
    op_info_t info;
    info = '{rs1_en: 1'b0, rs2_en: 1'b0, rd_en: 1'b0, lat: 3'd1};
    case (op)
      OP_ALU:   info = '{rs1_en: 1'b1, rs2_en: 1'b1, rd_en: 1'b1, lat: 3'd1};
      OP_ALUI:  info = '{rs1_en: 1'b1, rs2_en: 1'b0, rd_en: 1'b1, lat: 3'd1};
      OP_LOAD:  info = '{rs1_en: 1'b1, rs2_en: 1'b0, rd_en: 1'b1, lat: 3'd2};
      OP_STORE: info = '{rs1_en: 1'b1, rs2_en: 1'b1, rd_en: 1'b0, lat: 3'd1};
      OP_MUL:   info = '{rs1_en: 1'b1, rs2_en: 1'b1, rd_en: 1'b1, lat: 3'd3};
      OP_DIV:   info = '{rs1_en: 1'b1, rs2_en: 1'b1, rd_en: 1'b1, lat: 3'd4};
      OP_BR:    info = '{rs1_en: 1'b1, rs2_en: 1'b1, rd_en: 1'b0, lat: 3'd1};
      OP_JAL:   info = '{rs1_en: 1'b0, rs2_en: 1'b0, rd_en: 1'b1, lat: 3'd1};
      default:  info = '{rs1_en: 1'b0, rs2_en: 1'b0, rd_en: 1'b0, lat: 3'd1};
    endcase
    return info;
  endfunction

endpackage

// File: rtl/sb_entry.sv
// One register's pending-write countdown: load on issue, otherwise count down to idle.
module sb_entry #(
  parameter int CNT_W     = 3,
  parameter bit TIED_IDLE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             busy
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (TIED_IDLE) begin
      cnt <= '0;
    end else if (load) begin
      // a new writer replaces whatever was counting down this edge
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_scoreboard.sv
// ID-stage hazard unit: per-register writeback countdowns, forwarding source selection
// and stall generation for RAW, WAW reordering and writeback-port collisions.
module pipe_scoreboard
  import manta_pkg::*;
#(
  parameter int NUM_REGS  = 16,
  parameter int MAX_LAT   = 4,
  parameter int FWD_DEPTH = 2,
  parameter int ZERO_REG  = 1,
  localparam int REG_W    = sb_reg_w(NUM_REGS),
  localparam int CNT_W    = sb_cnt_w(MAX_LAT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_rs1,
  input  logic                id_rs1_en,
  input  logic [REG_W-1:0]    id_rs2,
  input  logic                id_rs2_en,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                id_rd_en,
  input  logic [CNT_W-1:0]    id_lat,
  input  logic                flush,
  output logic                stall,
  output logic                issue,
  output logic [1:0]          stall_why,
  output logic [CNT_W-1:0]    fwd_sel1,
  output logic [CNT_W-1:0]    fwd_sel2,
  output logic [NUM_REGS-1:0] busy_vec
);

  localparam logic [CNT_W-1:0] FWD_D = CNT_W'(FWD_DEPTH);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] load_vec;
  logic [MAX_LAT:1]    wb_sched;
  logic [MAX_LAT:1]    wb_next;

  logic             rs1_tracked, rs2_tracked, rd_tracked;
  logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd;
  logic             raw1, raw2, waw, wbp, wbp_hit;
  sb_why_e          why;

  assign rs1_tracked = (ZERO_REG == 0) || (id_rs1 != '0);
  assign rs2_tracked = (ZERO_REG == 0) || (id_rs2 != '0);
  assign rd_tracked  = (ZERO_REG == 0) || (id_rd != '0);

  assign cnt_rs1 = cnt[id_rs1];
  assign cnt_rs2 = cnt[id_rs2];
  assign cnt_rd  = cnt[id_rd];

  genvar r;
  generate
    for (r = 0; r < NUM_REGS; r++) begin : g_entry
      localparam bit TIE = (ZERO_REG != 0) && (r == 0);
      assign load_vec[r] = issue && id_rd_en && (id_rd == REG_W'(r));
      sb_entry #(
        .CNT_W    (CNT_W),
        .TIED_IDLE(TIE)
      ) u_entry (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load_vec[r]),
        .load_val(id_lat),
        .cnt     (cnt[r]),
        .busy    (busy_vec[r])
      );
    end
  endgenerate

  always_comb begin
    raw1 = id_rs1_en && rs1_tracked && (cnt_rs1 > FWD_D);
    raw2 = id_rs2_en && rs2_tracked && (cnt_rs2 > FWD_D);
    // an older writer still counting past our own writeback would land last
    waw  = id_rd_en && rd_tracked &&
           ({1'b0, cnt_rd} > ({1'b0, id_lat} + (CNT_W+1)'(1)));
    wbp_hit = 1'b0;
    for (int k = 1; k < MAX_LAT; k++) begin
      if ((id_lat == CNT_W'(k)) && wb_sched[k+1]) wbp_hit = 1'b1;
    end
    wbp = id_rd_en && wbp_hit;
  end

  always_comb begin
    why = SB_NONE;
    if (id_valid) begin
      if (raw1 || raw2)  why = SB_RAW;
      else if (waw)      why = SB_WAW;
      else if (wbp)      why = SB_WBP;
    end
  end

  assign stall     = (why != SB_NONE);
  assign stall_why = why;
  assign issue     = id_valid && !stall && !flush;

  always_comb begin
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    if (id_rs1_en && rs1_tracked && (cnt_rs1 <= FWD_D)) fwd_sel1 = cnt_rs1;
    if (id_rs2_en && rs2_tracked && (cnt_rs2 <= FWD_D)) fwd_sel2 = cnt_rs2;
  end

  // Bit k set means some in-flight op writes the RF k cycles from now
  always_comb begin
    wb_next = wb_sched >> 1;
    if (issue && id_rd_en && rd_tracked) begin
      for (int k = 1; k <= MAX_LAT; k++) begin
        if (id_lat == CNT_W'(k)) wb_next[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wb_sched <= '0;
    else        wb_sched <= wb_next;
  end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed, table-driven bench for pipe_scoreboard (16 regs, MAX_LAT 4, FWD_DEPTH 2).
module tb_pipe_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [3:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_en, id_rs2_en, id_rd_en;
  logic [2:0]  id_lat;
  logic        flush;
  logic        stall, issue;
  logic [1:0]  stall_why;
  logic [2:0]  fwd_sel1, fwd_sel2;
  logic [15:0] busy_vec;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_scoreboard #(
    .NUM_REGS(16), .MAX_LAT(4), .FWD_DEPTH(2), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_en(id_rs1_en),
    .id_rs2(id_rs2), .id_rs2_en(id_rs2_en),
    .id_rd(id_rd), .id_rd_en(id_rd_en), .id_lat(id_lat),
    .flush(flush), .stall(stall), .issue(issue), .stall_why(stall_why),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .busy_vec(busy_vec)
  );

  typedef struct {
    logic        valid;
    logic [3:0]  rs1;
    logic        rs1_en;
    logic [3:0]  rs2;
    logic        rs2_en;
    logic [3:0]  rd;
    logic        rd_en;
    logic [2:0]  lat;
    logic        flush;
    logic        e_stall;
    logic [1:0]  e_why;
    logic        e_issue;
    logic [2:0]  e_f1;
    logic [2:0]  e_f2;
    logic [15:0] e_busy;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int v, int rs1, int e1, int rs2, int e2, int rd, int erd,
                              int lat, int fl, int st, int why, int iss, int f1, int f2,
                              int busy);
    vec_t t;
    t.valid = v[0];    t.rs1 = rs1[3:0]; t.rs1_en = e1[0];
    t.rs2 = rs2[3:0];  t.rs2_en = e2[0]; t.rd = rd[3:0]; t.rd_en = erd[0];
    t.lat = lat[2:0];  t.flush = fl[0];
    t.e_stall = st[0]; t.e_why = why[1:0]; t.e_issue = iss[0];
    t.e_f1 = f1[2:0];  t.e_f2 = f2[2:0]; t.e_busy = busy[15:0];
    return t;
  endfunction

  function automatic vec_t idle(int busy);
    return mk(0, 0,0, 0,0, 0,0, 1, 0, 0,0,0, 0,0, busy);
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.valid; id_rs1 = t.rs1; id_rs1_en = t.rs1_en;
    id_rs2 = t.rs2; id_rs2_en = t.rs2_en; id_rd = t.rd; id_rd_en = t.rd_en;
    id_lat = t.lat; flush = t.flush;
  endtask

  // An out-of-range latency must never reach the scoreboard
  always @(negedge clk) begin
    if (rst_n && issue && id_rd_en && (id_lat == 3'd0 || id_lat > 3'd4)) begin
      fails++;
      $display("FAIL illegal_lat_issue: lat %0d issued", id_lat);
    end
  end

  initial begin
    //        v rs1 e rs2 e rd e lat fl | st why iss f1 f2 busy
    // back-to-back lat1 / lat2
    vq.push_back(mk(1, 0,0, 0,0, 3,1, 1, 0,  0,0,1, 0,0, 16'h0000));
    vq.push_back(mk(1, 3,1, 0,0, 0,0, 1, 0,  0,0,1, 1,0, 16'h0008));
    vq.push_back(idle(16'h0000));
    vq.push_back(mk(1, 0,0, 0,0, 3,1, 2, 0,  0,0,1, 0,0, 16'h0000));
    vq.push_back(mk(1, 3,1, 0,0, 0,0, 1, 0,  0,0,1, 2,0, 16'h0008));
    vq.push_back(idle(16'h0008));
    vq.push_back(idle(16'h0000));
    // long RAW on source 2
    vq.push_back(mk(1, 0,0, 0,0, 3,1, 4, 0,  0,0,1, 0,0, 16'h0000));
    vq.push_back(mk(1, 1,1, 3,1, 0,0, 1, 0,  1,1,0, 0,0, 16'h0008));
    vq.push_back(mk(1, 1,1, 3,1, 0,0, 1, 0,  1,1,0, 0,0, 16'h0008));
    vq.push_back(mk(1, 1,1, 3,1, 0,0, 1, 0,  0,0,1, 0,2, 16'h0008));
    vq.push_back(idle(16'h0008));
    vq.push_back(idle(16'h0000));
    // writeback port collision
    vq.push_back(mk(1, 0,0, 0,0, 4,1, 3, 0,  0,0,1, 0,0, 16'h0000));
    vq.push_back(mk(1, 0,0, 0,0, 5,1, 2, 0,  1,3,0, 0,0, 16'h0010));
    vq.push_back(mk(1, 0,0, 0,0, 5,1, 2, 0,  0,0,1, 0,0, 16'h0010));
    vq.push_back(idle(16'h0030));
    vq.push_back(idle(16'h0020));
    vq.push_back(idle(16'h0000));
    // WAW then WB port
    vq.push_back(mk(1, 0,0, 0,0, 6,1, 4, 0,  0,0,1, 0,0, 16'h0000));
    vq.push_back(mk(1, 0,0, 0,0, 6,1, 1, 0,  1,2,0, 0,0, 16'h0040));
    vq.push_back(mk(1, 0,0, 0,0, 6,1, 1, 0,  1,2,0, 0,0, 16'h0040));
    vq.push_back(mk(1, 0,0, 0,0, 6,1, 1, 0,  1,3,0, 0,0, 16'h0040));
    vq.push_back(mk(1, 0,0, 0,0, 6,1, 1, 0,  0,0,1, 0,0, 16'h0040));
    vq.push_back(idle(16'h0040));
    vq.push_back(idle(16'h0000));
    // R0 never tracked
    vq.push_back(mk(1, 0,0, 0,0, 0,1, 4, 0,  0,0,1, 0,0, 16'h0000));
    vq.push_back(mk(1, 0,1, 0,1, 0,1, 1, 0,  0,0,1, 0,0, 16'h0000));
    vq.push_back(idle(16'h0000));
    // flush squashes a write; flush with stall pending
    vq.push_back(mk(1, 0,0, 0,0, 7,1, 2, 1,  0,0,0, 0,0, 16'h0000));
    vq.push_back(mk(1, 7,1, 0,0, 0,0, 1, 0,  0,0,1, 0,0, 16'h0000));
    vq.push_back(mk(1, 0,0, 0,0, 8,1, 4, 0,  0,0,1, 0,0, 16'h0000));
    vq.push_back(mk(1, 8,1, 0,0, 0,0, 1, 1,  1,1,0, 0,0, 16'h0100));
    vq.push_back(mk(0, 8,1, 0,0, 0,0, 1, 0,  0,0,0, 0,0, 16'h0100));
    vq.push_back(idle(16'h0100));
    vq.push_back(idle(16'h0100));
    vq.push_back(idle(16'h0000));
    // source equals destination
    vq.push_back(mk(1, 0,0, 0,0, 9,1, 3, 0,  0,0,1, 0,0, 16'h0000));
    vq.push_back(mk(1, 9,1, 0,0, 9,1, 1, 0,  1,1,0, 0,0, 16'h0200));
    vq.push_back(mk(1, 9,1, 0,0, 9,1, 1, 0,  1,3,0, 2,0, 16'h0200));
    vq.push_back(mk(1, 9,1, 0,0, 9,1, 1, 0,  0,0,1, 1,0, 16'h0200));
    vq.push_back(idle(16'h0200));
    vq.push_back(idle(16'h0000));

    drive(idle(0));
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // reset state
    @(negedge clk);
    check("reset_busy", -1, busy_vec, 16'h0000);
    check("reset_stall", -1, stall, 0);
    check("reset_why", -1, stall_why, 0);
    @(posedge clk); #1;

    foreach (vq[i]) begin
      drive(vq[i]);
      @(negedge clk);
      check("stall", i, stall, vq[i].e_stall);
      check("stall_why", i, stall_why, vq[i].e_why);
      check("issue", i, issue, vq[i].e_issue);
      check("busy_vec", i, busy_vec, vq[i].e_busy);
      if (!vq[i].e_stall) begin
        check("fwd_sel1", i, fwd_sel1, vq[i].e_f1);
        check("fwd_sel2", i, fwd_sel2, vq[i].e_f2);
      end
      @(posedge clk); #1;
    end

    // asynchronous reset mid-run with r3 and r5 busy
    drive(mk(1, 0,0, 0,0, 3,1, 4, 0, 0,0,0, 0,0, 0));
    @(posedge clk); #1;
    drive(mk(1, 0,0, 0,0, 5,1, 4, 0, 0,0,0, 0,0, 0));
    @(posedge clk); #1;
    drive(mk(1, 3,1, 0,0, 0,0, 1, 0, 0,0,0, 0,0, 0));
    @(negedge clk);
    check("pre_rst_busy", 100, busy_vec, 16'h0028);
    check("pre_rst_stall", 100, stall, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 101, busy_vec, 16'h0000);
    check("rst_stall", 101, stall, 0);
    check("rst_fwd1", 101, fwd_sel1, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_stall", 102, stall, 0);
    check("post_rst_fwd1", 102, fwd_sel1, 0);
    check("post_rst_issue", 102, issue, 1);
    check("post_rst_busy", 102, busy_vec, 16'h0000);
    @(posedge clk); #1;
    drive(idle(0));
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
